// File: rtl/drc_pxl_assembler_if.sv
// drc_pxl_assembler_if: pixel-info input stream and packed pixel output stream
interface drc_pxl_assembler_if #(
  parameter int DVP_DATA_W   = 8,
  parameter int BYTE_PER_PXL = 2,
  parameter int COL_W        = 11,
  parameter int ROW_W        = 11,
  parameter int PXL_W        = DVP_DATA_W*BYTE_PER_PXL,
  parameter int PXL_INFO_W   = DVP_DATA_W+2
);
  logic [PXL_INFO_W-1:0] pxl_info_dat;
  logic                  pxl_info_vld;
  logic                  pxl_info_rdy;
  logic [PXL_W-1:0]      pxl_dat;
  logic [COL_W-1:0]      pxl_col;
  logic [ROW_W-1:0]      pxl_row;
  logic                  pxl_sof;
  logic                  pxl_sol;
  logic                  pxl_eol;
  logic                  pxl_vld;
  logic                  pxl_rdy;
  modport master (
    input  pxl_info_dat, pxl_info_vld, pxl_rdy,
    output pxl_info_rdy, pxl_dat, pxl_col, pxl_row, pxl_sof, pxl_sol, pxl_eol, pxl_vld
  );
  modport slave (
    output pxl_info_dat, pxl_info_vld, pxl_rdy,
    input  pxl_info_rdy, pxl_dat, pxl_col, pxl_row, pxl_sof, pxl_sol, pxl_eol, pxl_vld
  );
endinterface

// File: rtl/drc_pxl_assembler.sv
// drc_pxl_assembler: packs DVP bytes into position-tagged pixels on a registered valid/ready stream
module drc_pxl_assembler #(
  parameter int DVP_DATA_W   = 8,
  parameter int BYTE_PER_PXL = 2,
  parameter int PXL_W        = DVP_DATA_W*BYTE_PER_PXL,
  parameter int COL_W        = 11,
  parameter int ROW_W        = 11,
  parameter int PXL_INFO_W   = DVP_DATA_W+2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cam_rx_en,
  input  logic [COL_W-1:0]    cfg_img_w,
  drc_pxl_assembler_if.master bus,
  output logic                err_misalign,
  output logic                err_overrun
);
  localparam int IDX_W = BYTE_PER_PXL > 1 ? $clog2(BYTE_PER_PXL) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t                state, state_n;
  logic [IDX_W-1:0]      idx, idx_n, idx_b;
  logic [COL_W-1:0]      col, col_n, col_b;
  logic [ROW_W-1:0]      row, row_n, row_b;
  logic                  sof_pend, sof_pend_n, sol_pend, sol_pend_n;
  logic [PXL_W-1:0]      sh, sh_n;
  logic [DVP_DATA_W-1:0] byte_in;
  logic                  fs, ls, start, acc, proc, mis, ovr, last, load;
  // beat decode, next state and next datapath values
  always_comb begin
    fs = bus.pxl_info_dat[PXL_INFO_W-1];
    ls = bus.pxl_info_dat[PXL_INFO_W-2];
    byte_in = bus.pxl_info_dat[DVP_DATA_W-1:0];
    start = fs | ls;
    bus.pxl_info_rdy = (state == IDLE) | ~bus.pxl_vld | bus.pxl_rdy;
    acc = bus.pxl_info_vld & bus.pxl_info_rdy;
    proc = acc & cam_rx_en & ((state == ACTIVE) | fs);
    idx_b = start ? '0 : idx;
    col_b = start ? '0 : col;
    row_b = fs ? '0 : ls ? row + 1'b1 : row;
    mis = start & (idx != '0);
    ovr = ~start & (col == cfg_img_w);
    last = idx_b == IDX_W'(BYTE_PER_PXL-1);
    load = proc & ~ovr & last;
    sh_n = (proc & ~ovr) ? PXL_W'({sh, byte_in}) : sh;
    state_n = ~cam_rx_en ? IDLE : (acc & fs) ? ACTIVE : state;
    idx_n = ~cam_rx_en ? '0 : (proc & ~ovr) ? (last ? '0 : idx_b + 1'b1) : idx;
    col_n = proc ? (ovr ? col : col_b + COL_W'(last)) : col;
    row_n = proc ? row_b : row;
    sof_pend_n = proc ? (load ? 1'b0 : fs | sof_pend) : sof_pend;
    sol_pend_n = proc ? (load ? 1'b0 : start | sol_pend) : sol_pend;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // packing and position counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      col <= '0;
      row <= '0;
      sof_pend <= 1'b0;
      sol_pend <= 1'b0;
      sh <= '0;
    end else begin
      idx <= idx_n;
      col <= col_n;
      row <= row_n;
      sof_pend <= sof_pend_n;
      sol_pend <= sol_pend_n;
      sh <= sh_n;
    end
  // output pixel register and error pulses; a new pixel may load in the handshake cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.pxl_vld <= 1'b0;
      bus.pxl_dat <= '0;
      bus.pxl_col <= '0;
      bus.pxl_row <= '0;
      bus.pxl_sof <= 1'b0;
      bus.pxl_sol <= 1'b0;
      bus.pxl_eol <= 1'b0;
      err_misalign <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (load) begin
        bus.pxl_vld <= 1'b1;
        bus.pxl_dat <= sh_n;
        bus.pxl_col <= col_b;
        bus.pxl_row <= row_b;
        bus.pxl_sof <= fs | sof_pend;
        bus.pxl_sol <= start | sol_pend;
        bus.pxl_eol <= col_b == cfg_img_w - 1'b1;
      end else if (bus.pxl_rdy) bus.pxl_vld <= 1'b0;
      err_misalign <= proc & mis;
      err_overrun <= proc & ovr;
    end
endmodule
